// File: rtl/ca_pkg.sv
// Shared encodings for the elementary cellular automaton engine:
// boundary modes and controller states.
package ca_pkg;

  localparam logic [1:0] MODE_ZERO    = 2'b00;
  localparam logic [1:0] MODE_ONE     = 2'b01;
  localparam logic [1:0] MODE_WRAP    = 2'b10;
  localparam logic [1:0] MODE_REFLECT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ca_next_gen.sv
// One generation of a radius-1, 2-state automaton over a WIDTH-cell row.
// Bit WIDTH-1 is the leftmost cell; neighbourhood index is {L,C,R}.
module ca_next_gen
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] row,
  input  logic [7:0]       rule,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt_c
);

  logic             left_edge;
  logic             right_edge;
  logic [WIDTH+1:0] padded;

  // Pad the row with the boundary cells so every cell sees a full window.
  always_comb begin
    left_edge  = 1'b0;
    right_edge = 1'b0;
    nxt_c      = '0;
    unique case (mode)
      MODE_ZERO: begin
        left_edge  = 1'b0;
        right_edge = 1'b0;
      end
      MODE_ONE: begin
        left_edge  = 1'b1;
        right_edge = 1'b1;
      end
      MODE_WRAP: begin
        left_edge  = row[0];
        right_edge = row[WIDTH-1];
      end
      default: begin
        left_edge  = row[WIDTH-1];
        right_edge = row[0];
      end
    endcase
    padded = {left_edge, row, right_edge};
    for (int i = 0; i < int'(WIDTH); i++) begin
      nxt_c[i] = rule[padded[i+2 -: 3]];
    end
  end

endmodule

// File: rtl/cellular_automata_engine.sv
// Elementary cellular automaton engine: load, single-step, multi-generation
// run with halt, generation counter and fixed-point detection.
module cellular_automata_engine
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       RULE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] SEED,
  input  logic             LOAD,
  input  logic             START,
  input  logic [CNT_W-1:0] GENS,
  input  logic             STEP,
  input  logic             HALT,
  input  logic             STOP_ON_STABLE,
  output logic [WIDTH-1:0] OUTPUT,
  output logic [CNT_W-1:0] GEN_COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             STABLE
);

  state_t           state;
  logic [7:0]       rule_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] remaining;
  logic [7:0]       sel_rule;
  logic [1:0]       sel_mode;
  logic [WIDTH-1:0] nxt_c;
  logic             fixed_c;

  // A run uses the rule/mode captured at START; single steps use live inputs.
  assign sel_rule = (state == S_RUN) ? rule_q : RULE;
  assign sel_mode = (state == S_RUN) ? mode_q : MODE;
  assign fixed_c  = (nxt_c == OUTPUT);

  ca_next_gen #(.WIDTH(WIDTH)) u_next_gen (
    .row   (OUTPUT),
    .rule  (sel_rule),
    .mode  (sel_mode),
    .nxt_c (nxt_c)
  );

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      OUTPUT    <= '0;
      GEN_COUNT <= '0;
      STABLE    <= 1'b0;
      remaining <= '0;
      rule_q    <= '0;
      mode_q    <= MODE_ZERO;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (LOAD) begin
            OUTPUT    <= SEED;
            GEN_COUNT <= '0;
            STABLE    <= 1'b0;
            state     <= S_IDLE;
          end else if (START) begin
            rule_q <= RULE;
            mode_q <= MODE;
            if (GENS == '0) begin
              state <= S_DONE;
            end else begin
              remaining <= GENS;
              state     <= S_RUN;
            end
          end else if (STEP) begin
            OUTPUT    <= nxt_c;
            GEN_COUNT <= GEN_COUNT + CNT_W'(1);
            STABLE    <= fixed_c;
            state     <= S_IDLE;
          end
        end
        S_RUN: begin
          if (HALT) begin
            state <= S_IDLE;
          end else if (STOP_ON_STABLE && fixed_c) begin
            STABLE <= 1'b1;
            state  <= S_DONE;
          end else begin
            OUTPUT    <= nxt_c;
            GEN_COUNT <= GEN_COUNT + CNT_W'(1);
            STABLE    <= fixed_c;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cellular_automata_engine.sv
// Scoreboard bench for cellular_automata_engine: directed scenarios plus
// randomized traffic against a behavioural model of the automaton.
module tb_cellular_automata_engine;

  localparam int unsigned W = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rule;
  logic [1:0]    mode;
  logic [W-1:0]  seed;
  logic          load, start, step, halt, sos;
  logic [CW-1:0] gens;
  logic [W-1:0]  dut_row;
  logic [CW-1:0] dut_gc;
  logic          dut_busy, dut_done, dut_stable;

  cellular_automata_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK            (clk),
    .RST            (rst),
    .RULE           (rule),
    .MODE           (mode),
    .SEED           (seed),
    .LOAD           (load),
    .START          (start),
    .GENS           (gens),
    .STEP           (step),
    .HALT           (halt),
    .STOP_ON_STABLE (sos),
    .OUTPUT         (dut_row),
    .GEN_COUNT      (dut_gc),
    .BUSY           (dut_busy),
    .DONE           (dut_done),
    .STABLE         (dut_stable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  row;
    logic [CW-1:0] gc;
    logic          busy;
    logic          done;
    logic          stable;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // staged stimulus (pulses cleared after each cycle)
  logic          s_rst, s_load, s_start, s_step, s_halt, s_sos;
  logic [7:0]    s_rule;
  logic [1:0]    s_mode;
  logic [W-1:0]  s_seed;
  logic [CW-1:0] s_gens;

  // behavioural model state
  int            m_state;  // 0 idle, 1 run, 2 done
  logic [W-1:0]  m_row;
  logic [CW-1:0] m_gc;
  logic          m_stable;
  int            m_rem;
  logic [7:0]    m_rule_q;
  logic [1:0]    m_mode_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cell i sees left neighbour i+1 and right neighbour i-1; ext[j] holds cell j-1.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] r, input logic [7:0] ru,
                                            input logic [1:0] md);
    int ext[W+2];
    logic [W-1:0] res;
    int idx;
    for (int j = 1; j <= int'(W); j++) ext[j] = int'(r[j-1]);
    case (md)
      2'd0: begin ext[0] = 0; ext[W+1] = 0; end
      2'd1: begin ext[0] = 1; ext[W+1] = 1; end
      2'd2: begin ext[0] = int'(r[W-1]); ext[W+1] = int'(r[0]); end
      default: begin ext[0] = int'(r[0]); ext[W+1] = int'(r[W-1]); end
    endcase
    res = '0;
    for (int i = 0; i < int'(W); i++) begin
      idx = 4 * ext[i+2] + 2 * ext[i+1] + ext[i];
      res[i] = ((int'(ru) >> idx) % 2) == 1;
    end
    return res;
  endfunction

  task automatic model_update();
    logic [W-1:0] n;
    if (s_rst) begin
      m_state = 0; m_row = '0; m_gc = '0; m_stable = 1'b0; m_rem = 0;
    end else if (m_state == 1) begin
      if (s_halt) begin
        m_state = 0;
      end else begin
        n = ref_next(m_row, m_rule_q, m_mode_q);
        if (s_sos && n == m_row) begin
          m_stable = 1'b1;
          m_state  = 2;
        end else begin
          m_stable = (n == m_row);
          m_row    = n;
          m_gc     = m_gc + 1'b1;
          if (m_rem == 1) m_state = 2;
          m_rem = m_rem - 1;
        end
      end
    end else begin
      if (s_load) begin
        m_row = s_seed; m_gc = '0; m_stable = 1'b0; m_state = 0;
      end else if (s_start) begin
        m_rule_q = s_rule;
        m_mode_q = s_mode;
        if (s_gens == 0) m_state = 2;
        else begin
          m_rem   = int'(s_gens);
          m_state = 1;
        end
      end else if (s_step) begin
        n = ref_next(m_row, s_rule, s_mode);
        m_stable = (n == m_row);
        m_row    = n;
        m_gc     = m_gc + 1'b1;
        m_state  = 0;
      end
    end
  endtask

  // Drive one clock of stimulus and queue the state expected after the edge.
  task automatic cycle();
    @(negedge clk);
    rst = s_rst; load = s_load; start = s_start; step = s_step; halt = s_halt;
    sos = s_sos; rule = s_rule; mode = s_mode; seed = s_seed; gens = s_gens;
    model_update();
    sbq.push_back('{row: m_row, gc: m_gc, busy: (m_state == 1), done: (m_state == 2),
                    stable: m_stable});
    s_rst = 1'b0; s_load = 1'b0; s_start = 1'b0; s_step = 1'b0; s_halt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the engine presents its state every cycle, compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_row",    32'(dut_row),    32'(e.row));
        chk("sb_gc",     32'(dut_gc),     32'(e.gc));
        chk("sb_busy",   32'(dut_busy),   32'(e.busy));
        chk("sb_done",   32'(dut_done),   32'(e.done));
        chk("sb_stable", 32'(dut_stable), 32'(e.stable));
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; load = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; sos = 1'b0;
    rule = '0; mode = '0; seed = '0; gens = '0;
    s_rst = 1'b0; s_load = 1'b0; s_start = 1'b0; s_step = 1'b0; s_halt = 1'b0;
    s_sos = 1'b0; s_rule = '0; s_mode = '0; s_seed = '0; s_gens = '0;
    m_state = 0; m_row = '0; m_gc = '0; m_stable = 1'b0; m_rem = 0;
    m_rule_q = '0; m_mode_q = '0;

    for (int i = 0; i < 3; i++) begin s_rst = 1'b1; cycle(); end
    settle();
    chk("reset_row", 32'(dut_row), 32'h0);
    chk("reset_busy_done", 32'({dut_busy, dut_done, dut_stable}), 32'h0);

    // rule 110 stepping in zero mode
    s_rule = 8'h6E; s_mode = 2'd0; s_seed = 8'h10; s_load = 1'b1; cycle();
    s_step = 1'b1; cycle(); settle();
    chk("r110_step1", 32'(dut_row), 32'h30);
    s_step = 1'b1; cycle(); settle();
    chk("r110_step2", 32'(dut_row), 32'h70);
    chk("r110_gc", 32'(dut_gc), 32'd2);
    chk("r110_stable", 32'(dut_stable), 32'd0);

    // rule 90 under wrap and zero boundaries
    s_rule = 8'h5A; s_mode = 2'd2; s_seed = 8'h01; s_load = 1'b1; cycle();
    s_step = 1'b1; cycle(); settle();
    chk("r90_wrap", 32'(dut_row), 32'h82);
    s_mode = 2'd0; s_load = 1'b1; cycle();
    s_step = 1'b1; cycle(); settle();
    chk("r90_zero", 32'(dut_row), 32'h02);

    // rule 0 run with early stop at the fixed point
    s_rule = 8'h00; s_seed = 8'hFF; s_sos = 1'b1; s_load = 1'b1; cycle();
    s_gens = 16'd10; s_start = 1'b1; cycle();
    cycle(); settle();
    chk("stop_row", 32'(dut_row), 32'h00);
    chk("stop_busy", 32'(dut_busy), 32'd1);
    cycle(); settle();
    chk("stop_done", 32'(dut_done), 32'd1);
    chk("stop_gc", 32'(dut_gc), 32'd1);
    chk("stop_stable", 32'(dut_stable), 32'd1);

    // same without early stop runs all ten generations
    s_sos = 1'b0; s_load = 1'b1; cycle();
    s_start = 1'b1; cycle();
    idle(9); settle();
    chk("full_busy_k9", 32'(dut_busy), 32'd1);
    cycle(); settle();
    chk("full_done", 32'(dut_done), 32'd1);
    chk("full_gc", 32'(dut_gc), 32'd10);

    // rule change while busy is ignored; halt in the third run cycle
    s_rule = 8'h6E; s_mode = 2'd0; s_seed = 8'h10; s_load = 1'b1; cycle();
    s_gens = 16'd5; s_start = 1'b1; cycle();
    s_rule = 8'h00; cycle(); cycle();
    s_halt = 1'b1; cycle(); settle();
    chk("halt_busy", 32'(dut_busy), 32'd0);
    chk("halt_done", 32'(dut_done), 32'd0);
    chk("halt_gc", 32'(dut_gc), 32'd2);
    chk("halt_row", 32'(dut_row), 32'(ref_next(ref_next(8'h10, 8'h6E, 2'd0), 8'h6E, 2'd0)));

    // zero-generation start, then load+start collision
    held = m_row;
    s_gens = 16'd0; s_start = 1'b1; cycle(); settle();
    chk("gens0_done", 32'(dut_done), 32'd1);
    chk("gens0_row", 32'(dut_row), 32'(held));
    s_seed = 8'hA5; s_gens = 16'd4; s_load = 1'b1; s_start = 1'b1; cycle(); settle();
    chk("loadstart_row", 32'(dut_row), 32'hA5);
    chk("loadstart_idle", 32'({dut_busy, dut_done}), 32'd0);

    // reset mid-run, then a normal run
    s_rule = 8'h1E; s_gens = 16'd8; s_start = 1'b1; cycle();
    cycle();
    s_rst = 1'b1; cycle(); settle();
    chk("rst_row", 32'(dut_row), 32'h0);
    chk("rst_flags", 32'({dut_busy, dut_done, dut_stable}), 32'd0);
    chk("rst_gc", 32'(dut_gc), 32'd0);
    s_seed = 8'h3C; s_load = 1'b1; cycle();
    s_gens = 16'd3; s_start = 1'b1; cycle();
    idle(3); settle();
    chk("after_rst_done", 32'(dut_done), 32'd1);
    chk("after_rst_gc", 32'(dut_gc), 32'd3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom % 200) == 0;
      s_load  = ($urandom % 10) == 0;
      s_start = ($urandom % 8) == 0;
      s_step  = ($urandom % 6) == 0;
      s_halt  = ($urandom % 15) == 0;
      s_sos   = 1'($urandom % 2);
      s_rule  = 8'($urandom);
      s_mode  = 2'($urandom);
      s_seed  = W'($urandom);
      s_gens  = CW'($urandom_range(0, 12));
      cycle();
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cellular_automata_engine.md
Name: cellular_automata_engine

Overview:
Parametrised elementary (radius-1, 2-state) cellular automaton engine. Generalises the fixed 8-cell simulator: configurable row width, selectable boundary mode, explicit load, multi-generation run with done handshake, single-step, halt, generation counter and fixed-point detection. Sits beside the existing simulator as the core for wide-row and batch-run use.

Parameters:
WIDTH, 8, number of cells in the row (>=3)
CNT_W, 16, width of generation counter and GENS request

Ports:
CLK  input  1  clock, all state changes on rising edge
RST  input  1  synchronous, active-high reset
RULE  input  8  Wolfram rule number; bit index = {L,C,R}
MODE  input  2  boundary mode: 00 zero, 01 one, 10 wrap, 11 reflect
SEED  input  WIDTH  initial row for LOAD
LOAD  input  1  pulse: OUTPUT<=SEED
START  input  1  pulse: run GENS generations
GENS  input  CNT_W  generations requested at START
STEP  input  1  pulse: apply exactly one generation
HALT  input  1  pulse: abort run, keep current row
STOP_ON_STABLE  input  1  end run early at a fixed point
OUTPUT  output  WIDTH  current row; bit WIDTH-1 leftmost
GEN_COUNT  output  CNT_W  generations applied since last LOAD
BUSY  output  1  high in RUN
DONE  output  1  high in DONE
STABLE  output  1  last evaluated generation equalled its predecessor

Behaviour:
- Clock CLK; reset RST is synchronous and active-high. RST has priority over all inputs, including mid-run: OUTPUT=0, GEN_COUNT=0, BUSY=0, DONE=0, STABLE=0, state IDLE, remaining=0.
- Neighbourhood of cell i: L=cell i+1, C=cell i, R=cell i-1. Next cell = rule[{L,C,R}]. All cells update simultaneously.
- Missing neighbours at the edges depend on MODE:
  - zero: constant 0.
  - one: constant 1.
  - wrap: left of bit WIDTH-1 is bit 0; right of bit 0 is bit WIDTH-1.
  - reflect: a missing neighbour equals the edge cell itself.
- Rule/mode source: RULE and MODE are latched into rule_q/mode_q on START. RUN uses the latched values, so changes to RULE/MODE during BUSY have no effect. STEP uses the live RULE/MODE.
- States: IDLE, RUN, DONE.
- IDLE/DONE, priority LOAD > START > STEP; lower-priority pulses in the same cycle are dropped:
  - LOAD: OUTPUT<=SEED, GEN_COUNT<=0, STABLE<=0, go to IDLE.
  - START with GENS=0: go directly to DONE; no row change.
  - START with GENS>0: remaining<=GENS, go to RUN.
  - STEP: apply one generation, GEN_COUNT+1, STABLE<=(next==OUTPUT), go to IDLE.
  - HALT: ignored.
- RUN (BUSY=1), evaluated each cycle:
  - HALT: go to IDLE, no generation applied this cycle. HALT takes priority over everything else in RUN.
  - Fixed point with STOP_ON_STABLE=1 (next==OUTPUT): STABLE<=1, go to DONE, GEN_COUNT unchanged.
  - Otherwise: apply the generation, GEN_COUNT+1, STABLE<=(next==OUTPUT), remaining-1. Go to DONE when remaining was 1.
  - LOAD, START and STEP are ignored.
- Latency: START sampled at edge k. Generations are applied at edges k+1..k+GENS. BUSY is high from after edge k to edge k+GENS. DONE rises after edge k+GENS.
- DONE is a level, held until the next accepted LOAD, START or STEP.
- GEN_COUNT wraps modulo 2^CNT_W.
- OUTPUT, GEN_COUNT and the flags are all registered; no combinational input-to-output paths.

Decomposition:
- Package ca_pkg:
  - MODE encodings: MODE_ZERO, MODE_ONE, MODE_WRAP, MODE_REFLECT.
  - State encodings: S_IDLE, S_RUN, S_DONE.
- Sub-module ca_next_gen (combinational, parameter WIDTH): inputs row, rule, mode; output next row. The engine instantiates one and muxes rule/mode between live and latched values.

Test Plan:
- WIDTH=8, RULE=0x6E, MODE=zero, LOAD SEED=0x10, STEP twice -> OUTPUT 0x30 then 0x70; GEN_COUNT=2; STABLE=0.
- RULE=0x5A (90), SEED=0x01, STEP with MODE=wrap -> 0x82. Reload, STEP with MODE=zero -> 0x02.
- RULE=0x00, SEED=0xFF, STOP_ON_STABLE=1, START GENS=10 -> OUTPUT=0x00 after 1 cycle, DONE after the 2nd cycle, GEN_COUNT=1, STABLE=1. Same with STOP_ON_STABLE=0 -> DONE after 10 cycles, GEN_COUNT=10.
- START GENS=5 with RULE=0x6E; change RULE to 0x00 during BUSY; HALT in cycle 3 -> BUSY drops, state IDLE, GEN_COUNT=2, row matches two rule-110 generations; DONE=0.
- START GENS=0 -> DONE next cycle, OUTPUT unchanged. LOAD+START in the same cycle -> load only, stay IDLE.
- RST asserted mid-run -> next cycle all outputs 0, IDLE; subsequent START runs normally.
